l2_state_wr_arb: RTL and testbench



---
 rtl/l2_state_wr_arb_pkg.sv | 21 ++
 rtl/l2_state_wr_arb_if.sv | 46 ++++
 rtl/l2_state_wr_arb_starve_ctr.sv | 23 ++
 rtl/l2_state_wr_arb.sv | 117 +++++++++++
 tb/tb_l2_state_wr_arb.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/l2_state_wr_arb_pkg.sv
// Shared widths, write-request type and the same-index merge helper for the L2 state write arbiter.
package l2_wr_arb_pkg;
  localparam int L2_STATE_IDX_W  = 8;
  localparam int L2_STATE_DATA_W = 66;
  localparam int STARVE_CNT_W    = 4;

  typedef struct packed {
    logic [L2_STATE_IDX_W-1:0]  idx;
    logic [L2_STATE_DATA_W-1:0] data;
    logic [L2_STATE_DATA_W-1:0] mask;
  } l2_wr_req_t;

  // req_a owns any bit that both requests enable.
  function automatic l2_wr_req_t wr_merge(input l2_wr_req_t req_a, input l2_wr_req_t req_b);
    l2_wr_req_t res;
    res.idx  = req_a.idx;
    res.mask = req_a.mask | req_b.mask;
    res.data = (req_a.data & req_a.mask) | (req_b.data & req_b.mask & ~req_a.mask);
    return res;
  endfunction
endpackage

// File: rtl/l2_state_wr_arb_if.sv
// Bundle of both pipes' write requests, the read probe, the SRAM write port and the bypass triple.
interface l2_state_wr_arb_if import l2_wr_arb_pkg::*; #(
  parameter int IDX_W  = L2_STATE_IDX_W,
  parameter int DATA_W = L2_STATE_DATA_W
);
  // Handshake: a write transfers on val && rdy at the rising edge; while val && !rdy the
  // requester keeps val high and idx/data/mask unchanged. rdy is combinational from both vals.
  logic              p1_wr_val;
  logic              p1_wr_rdy;
  logic [IDX_W-1:0]  p1_wr_idx;
  logic [DATA_W-1:0] p1_wr_data;
  logic [DATA_W-1:0] p1_wr_mask;
  logic              p2_wr_val;
  logic              p2_wr_rdy;
  logic [IDX_W-1:0]  p2_wr_idx;
  logic [DATA_W-1:0] p2_wr_data;
  logic [DATA_W-1:0] p2_wr_mask;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_idx;
  logic              sram_wr_en;
  logic [IDX_W-1:0]  sram_wr_idx;
  logic [DATA_W-1:0] sram_wr_data;
  logic [DATA_W-1:0] sram_wr_mask;
  logic              bypass_next;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_mask_in;
  logic [STARVE_CNT_W-1:0] starve_cnt;

  modport master (
    output p1_wr_val, p1_wr_idx, p1_wr_data, p1_wr_mask,
    output p2_wr_val, p2_wr_idx, p2_wr_data, p2_wr_mask,
    output rd_en, rd_idx,
    input  p1_wr_rdy, p2_wr_rdy,
    input  sram_wr_en, sram_wr_idx, sram_wr_data, sram_wr_mask,
    input  bypass_next, data_in, data_mask_in, starve_cnt
  );

  modport slave (
    input  p1_wr_val, p1_wr_idx, p1_wr_data, p1_wr_mask,
    input  p2_wr_val, p2_wr_idx, p2_wr_data, p2_wr_mask,
    input  rd_en, rd_idx,
    output p1_wr_rdy, p2_wr_rdy,
    output sram_wr_en, sram_wr_idx, sram_wr_data, sram_wr_mask,
    output bypass_next, data_in, data_mask_in, starve_cnt
  );
endinterface

// File: rtl/l2_state_wr_arb_starve_ctr.sv
// Saturating pipe1 loss counter; at_max forces pipe1 to win the next contested cycle.
module l2_wr_arb_starve_ctr import l2_wr_arb_pkg::*; #(
  parameter int MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inc,
  input  logic                    clr,
  output logic                    at_max,
  output logic [STARVE_CNT_W-1:0] cnt
);
  localparam logic [STARVE_CNT_W-1:0] MAX_V = STARVE_CNT_W'(MAX);

  assign at_max = (cnt == MAX_V);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/l2_state_wr_arb.sv
// Arbitrates pipe1/pipe2 state writes onto the single SRAM write port and builds the read bypass.
// Optional build macro: L2_WR_MERGE_EN (same-index requests from both pipes merge into one write).
module l2_state_wr_arb import l2_wr_arb_pkg::*; #(
  parameter int IDX_W      = L2_STATE_IDX_W,
  parameter int DATA_W     = L2_STATE_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input logic              clk,
  input logic              rst,
  l2_state_wr_arb_if.slave bus
);
  l2_wr_req_t              p1_req;
  l2_wr_req_t              p2_req;
  l2_wr_req_t              win_req;
  l2_wr_req_t              wr_q;
  logic                    wr_en_q;
  logic                    merge;
  logic                    at_max;
  logic                    p1_rdy;
  logic                    p2_rdy;
  logic                    acc;
  logic                    p1_lose;
  logic                    collide;
  logic                    bypass_q;
  logic [DATA_W-1:0]       data_in_q;
  logic [DATA_W-1:0]       mask_in_q;
  logic [STARVE_CNT_W-1:0] starve_cnt;

  always_comb begin
    p1_req.idx  = bus.p1_wr_idx;
    p1_req.data = bus.p1_wr_data;
    p1_req.mask = bus.p1_wr_mask;
    p2_req.idx  = bus.p2_wr_idx;
    p2_req.data = bus.p2_wr_data;
    p2_req.mask = bus.p2_wr_mask;
  end

`ifdef L2_WR_MERGE_EN
  assign merge = bus.p1_wr_val && bus.p2_wr_val && (bus.p1_wr_idx == bus.p2_wr_idx);
`else
  assign merge = 1'b0;
`endif

  // Memory acks drain first; pipe1 only wins a contested cycle once it has lost STARVE_MAX times.
  assign p1_rdy  = bus.p1_wr_val && (!bus.p2_wr_val || at_max || merge);
  assign p2_rdy  = bus.p2_wr_val && (!bus.p1_wr_val || !at_max || merge);
  assign acc     = p1_rdy || p2_rdy;
  assign p1_lose = bus.p1_wr_val && !p1_rdy;

  always_comb begin
    win_req = p2_req;
    if (merge) begin
      win_req = wr_merge(p2_req, p1_req);
    end else if (p1_rdy) begin
      win_req = p1_req;
    end
  end

  l2_wr_arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (p1_lose),
    .clr    (!p1_lose),
    .at_max (at_max),
    .cnt    (starve_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q <= 1'b0;
      wr_q    <= '0;
    end else begin
      wr_en_q <= acc;
      if (acc) begin
        wr_q <= win_req;
      end
    end
  end

  // The array returns pre-write data, so a read hitting the in-flight write gets it merged next cycle.
  assign collide = bus.rd_en && wr_en_q && (bus.rd_idx == IDX_W'(wr_q.idx));

  always_ff @(posedge clk) begin
    if (rst) begin
      bypass_q  <= 1'b0;
      data_in_q <= '0;
      mask_in_q <= '0;
    end else begin
      bypass_q  <= collide;
      data_in_q <= DATA_W'(wr_q.data);
      if (collide) begin
        mask_in_q <= DATA_W'(wr_q.mask);
      end
    end
  end

  assign bus.p1_wr_rdy    = p1_rdy;
  assign bus.p2_wr_rdy    = p2_rdy;
  assign bus.sram_wr_en   = wr_en_q;
  assign bus.sram_wr_idx  = IDX_W'(wr_q.idx);
  assign bus.sram_wr_data = DATA_W'(wr_q.data);
  assign bus.sram_wr_mask = DATA_W'(wr_q.mask);
  assign bus.bypass_next  = bypass_q;
  assign bus.data_in      = data_in_q;
  assign bus.data_mask_in = mask_in_q;
  assign bus.starve_cnt   = starve_cnt;

  a_p1_hold: assert property (@(posedge clk) disable iff (rst)
    (bus.p1_wr_val && !p1_rdy) ##1 bus.p1_wr_val |-> $stable({bus.p1_wr_idx, bus.p1_wr_data, bus.p1_wr_mask}));
  a_p2_hold: assert property (@(posedge clk) disable iff (rst)
    (bus.p2_wr_val && !p2_rdy) ##1 bus.p2_wr_val |-> $stable({bus.p2_wr_idx, bus.p2_wr_data, bus.p2_wr_mask}));
`ifdef L2_WR_MERGE_EN
  a_dual_rdy: assert property (@(posedge clk) (p1_rdy && p2_rdy) |-> (bus.p1_wr_idx == bus.p2_wr_idx));
`else
  a_dual_rdy: assert property (@(posedge clk) !(p1_rdy && p2_rdy));
`endif
endmodule

// File: tb/tb_l2_state_wr_arb.sv
// Bench for l2_state_wr_arb: directed cases plus random traffic against an array/arbitration model.
module tb_l2_state_wr_arb;
  localparam int STARVE_MAX = 4;
  localparam int W = 141;
`ifdef L2_WR_MERGE_EN
  localparam bit MERGE_ON = 1'b1;
`else
  localparam bit MERGE_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  l2_state_wr_arb_if #(.IDX_W(8), .DATA_W(66)) bus ();

  l2_state_wr_arb #(.IDX_W(8), .DATA_W(66), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int            checks = 0;
  int            errors = 0;
  logic [W-1:0]  exp_q[$];
  logic [65:0]   rd_q[$];
  logic [65:0]   ref_mem [256];
  logic [65:0]   sram [256];
  logic [65:0]   arr_out;
  logic          rd_chk_q;
  int            losses = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [65:0] rnd66();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[65:0];
  endfunction

  // Environment copy of the state array: registered read of pre-write contents, masked write.
  always @(posedge clk) begin
    if (bus.sram_wr_en === 1'b1)
      sram[bus.sram_wr_idx] <= (bus.sram_wr_data & bus.sram_wr_mask) | (sram[bus.sram_wr_idx] & ~bus.sram_wr_mask);
    arr_out  <= sram[bus.rd_idx];
    rd_chk_q <= bus.rd_en && !rst;
  end

  // Monitor: one expected write-stage entry per driven cycle, one expected read per checked read.
  logic [W-1:0] mon_e;
  logic [W-1:0] mon_a;
  logic [65:0]  mon_m;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {bus.sram_wr_en, bus.sram_wr_idx, bus.sram_wr_data, bus.sram_wr_mask};
      if (mon_e[W-1] == 1'b0) mon_a[W-2:0] = '0;
      chk("sram_wr", mon_a, mon_e);
    end
    if (rd_chk_q) begin
      mon_m = bus.bypass_next ? ((bus.data_in & bus.data_mask_in) | (arr_out & ~bus.data_mask_in)) : arr_out;
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_data actual=%h expected=<none queued>", mon_m);
      end else begin
        chk("rd_data", mon_m, rd_q.pop_front());
      end
    end
  end

  // Drive one cycle, predict grants/write/read from the arbitration rules, and check rdy/starve.
  task automatic step(input logic r, input logic p1v, input logic [7:0] i1, input logic [65:0] d1,
                      input logic [65:0] m1, input logic p2v, input logic [7:0] i2, input logic [65:0] d2,
                      input logic [65:0] m2, input logic rde, input logic [7:0] ri,
                      output logic g1, output logic g2);
    logic        mrg;
    logic [7:0]  widx;
    logic [65:0] wd;
    logic [65:0] wm;
    @(negedge clk);
    rst = r;
    bus.p1_wr_val = p1v; bus.p1_wr_idx = i1; bus.p1_wr_data = d1; bus.p1_wr_mask = m1;
    bus.p2_wr_val = p2v; bus.p2_wr_idx = i2; bus.p2_wr_data = d2; bus.p2_wr_mask = m2;
    bus.rd_en = rde; bus.rd_idx = ri;
    #1;
    if (rde && !r) rd_q.push_back(ref_mem[ri]);
    mrg = MERGE_ON && p1v && p2v && (i1 == i2);
    if (mrg) begin
      g1 = 1'b1; g2 = 1'b1;
    end else if (p1v && p2v) begin
      g1 = (losses >= STARVE_MAX); g2 = !g1;
    end else begin
      g1 = p1v; g2 = p2v;
    end
    chk("p1_rdy", W'(bus.p1_wr_rdy), W'(g1));
    chk("p2_rdy", W'(bus.p2_wr_rdy), W'(g2));
    chk("starve_cnt", W'(bus.starve_cnt), W'(losses));
    widx = i2; wd = d2; wm = m2;
    if (mrg) begin
      wm = m1 | m2; wd = (d2 & m2) | (d1 & m1 & ~m2);
    end else if (g1) begin
      widx = i1; wd = d1; wm = m1;
    end
    if (!r && (g1 || g2)) begin
      exp_q.push_back({1'b1, widx, wd, wm});
      ref_mem[widx] = (wd & wm) | (ref_mem[widx] & ~wm);
    end else begin
      exp_q.push_back('0);
    end
    if (r) losses = 0;
    else if (p1v && !g1) losses = (losses + 1 > STARVE_MAX) ? STARVE_MAX : losses + 1;
    else losses = 0;
  endtask

  logic        g1, g2, r;
  logic        h1v, h2v, rde;
  logic [7:0]  h1i, h2i, ri;
  logic [65:0] h1d, h1m, h2d, h2m, dd, mm;
  logic [9:0]  exp_pat;
  localparam logic [65:0] Z = '0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = '0;
      sram[i] = '0;
    end
    rst = 1'b1;
    bus.p1_wr_val = 0; bus.p1_wr_idx = 0; bus.p1_wr_data = 0; bus.p1_wr_mask = 0;
    bus.p2_wr_val = 0; bus.p2_wr_idx = 0; bus.p2_wr_data = 0; bus.p2_wr_mask = 0;
    bus.rd_en = 0; bus.rd_idx = 0;

    // Reset state.
    for (int i = 0; i < 3; i++) step(1, 0, 0, Z, Z, 0, 0, Z, Z, 0, 0, g1, g2);
    @(posedge clk); #2;
    chk("rst_wr_en", W'(bus.sram_wr_en), W'(0));
    chk("rst_bypass", W'(bus.bypass_next), W'(0));
    chk("rst_data_in", W'(bus.data_in), W'(0));
    chk("rst_mask_in", W'(bus.data_mask_in), W'(0));

    // Single pipe1 write, visible on the SRAM port one cycle later.
    step(0, 1, 8'h12, '1, 66'h3, 0, 0, Z, Z, 0, 0, g1, g2);
    chk("single_rdy", W'(bus.p1_wr_rdy), W'(1));
    @(posedge clk); #2;
    chk("single_en", W'(bus.sram_wr_en), W'(1));
    chk("single_idx", W'(bus.sram_wr_idx), W'(8'h12));
    chk("single_mask", W'(bus.sram_wr_mask), W'(66'h3));
    step(0, 0, 0, Z, Z, 0, 0, Z, Z, 0, 0, g1, g2);

    // Continuous contention: pipe2 four times, then pipe1.
    exp_pat = 10'b10000_10000;
    for (int k = 0; k < 10; k++) begin
      step(0, 1, 8'h01, 66'h11, 66'hff, 1, 8'h02, 66'h22, 66'hff, 0, 0, g1, g2);
      chk("starve_pat", W'(bus.p1_wr_rdy), W'(exp_pat[k]));
    end
    step(0, 0, 0, Z, Z, 0, 0, Z, Z, 0, 0, g1, g2);

    // Read colliding with the write-stage entry, then a non-colliding read.
    dd = rnd66(); mm = rnd66() | 66'h1;
    step(0, 1, 8'h05, dd, mm, 0, 0, Z, Z, 0, 0, g1, g2);
    step(0, 0, 0, Z, Z, 0, 0, Z, Z, 1, 8'h05, g1, g2);
    @(posedge clk); #2;
    chk("byp_hit", W'(bus.bypass_next), W'(1));
    chk("byp_data", W'(bus.data_in), W'(dd));
    chk("byp_mask", W'(bus.data_mask_in), W'(mm));
    step(0, 1, 8'h05, rnd66(), rnd66(), 0, 0, Z, Z, 0, 0, g1, g2);
    step(0, 0, 0, Z, Z, 0, 0, Z, Z, 1, 8'h06, g1, g2);
    @(posedge clk); #2;
    chk("byp_miss", W'(bus.bypass_next), W'(0));

    // Reset with a write in the SRAM stage, another being accepted, and a colliding read.
    dd = rnd66();
    step(0, 1, 8'h40, dd, '1, 1, 8'h41, 66'h7, '1, 0, 0, g1, g2);
    step(0, 1, 8'h40, dd, '1, 1, 8'h42, 66'h9, '1, 0, 0, g1, g2);
    step(1, 1, 8'h40, dd, '1, 1, 8'h43, 66'hb, '1, 1, 8'h42, g1, g2);
    @(posedge clk); #2;
    chk("rstmid_wr_en", W'(bus.sram_wr_en), W'(0));
    chk("rstmid_bypass", W'(bus.bypass_next), W'(0));
    chk("rstmid_starve", W'(bus.starve_cnt), W'(0));
    step(0, 0, 0, Z, Z, 0, 0, Z, Z, 0, 0, g1, g2);

    // Same-index requests from both pipes.
    step(0, 1, 8'h07, 66'h05, 66'h0f, 1, 8'h07, 66'h28, 66'h3c, 0, 0, g1, g2);
`ifdef L2_WR_MERGE_EN
    chk("merge_rdy", W'({bus.p1_wr_rdy, bus.p2_wr_rdy}), W'(2'b11));
    @(posedge clk); #2;
    chk("merge_mask", W'(bus.sram_wr_mask), W'(66'h3f));
    chk("merge_data", W'(bus.sram_wr_data), W'(66'h29));
`else
    @(posedge clk); #2;
    chk("same_idx_w0", W'({bus.sram_wr_data, bus.sram_wr_mask}), W'({66'h28, 66'h3c}));
    step(0, 1, 8'h07, 66'h05, 66'h0f, 0, 0, Z, Z, 0, 0, g1, g2);
    @(posedge clk); #2;
    chk("same_idx_w1", W'({bus.sram_wr_data, bus.sram_wr_mask}), W'({66'h05, 66'h0f}));
`endif
    step(0, 0, 0, Z, Z, 0, 0, Z, Z, 0, 0, g1, g2);

    // Random traffic on a small index range so collisions and merges are frequent.
    h1v = 0; h2v = 0; h1i = 0; h2i = 0; h1d = 0; h1m = 0; h2d = 0; h2m = 0;
    for (int c = 0; c < 10000; c++) begin
      r = ($urandom_range(0, 499) == 0);
      if (!h1v && $urandom_range(0, 9) < 7) begin
        h1v = 1; h1i = 8'($urandom_range(0, 7)); h1d = rnd66(); h1m = rnd66();
      end
      if (!h2v && $urandom_range(0, 9) < 7) begin
        h2v = 1; h2i = 8'($urandom_range(0, 7)); h2d = rnd66(); h2m = rnd66();
      end
      rde = !r && ($urandom_range(0, 1) == 1);
      ri = 8'($urandom_range(0, 7));
      step(r, h1v, h1i, h1d, h1m, h2v, h2i, h2d, h2m, rde, ri, g1, g2);
      if (g1) h1v = 0;
      if (g2) h2v = 0;
    end

    // Read back every touched index through the bypass path.
    for (int i = 0; i < 8; i++) step(0, 0, 0, Z, Z, 0, 0, Z, Z, 1, 8'(i), g1, g2);
    step(0, 0, 0, Z, Z, 0, 0, Z, Z, 0, 0, g1, g2);
    repeat (3) @(posedge clk);
    #2;
    chk("exp_q_drain", W'(exp_q.size()), W'(0));
    chk("rd_q_drain", W'(rd_q.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
